// File: rtl/system_nios2_ocimem_sequencer.sv
// Sysclk-side ocimem sequencer: turns JTAG debug strobes into single-word debug RAM cycles.
// Define OCIMEM_TIMEOUT_EN to add a waitrequest watchdog of TIMEOUT cycles.
module system_nios2_ocimem_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitrequest
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lat_cnt;

    logic idle;
    logic any_strobe;
    logic cmd_a;
    logic cmd_b;
    logic cmd_n;
    logic cmd_drop;
    logic clr_err;
    logic rd_accept;
    logic wr_accept;
    logic rd_done;
    logic timeout;
    logic unused_ok;

    // Only one command is decoded per cycle, and only from IDLE; ocimem_a outranks the rest.
    assign idle       = (state == IDLE);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign cmd_a      = idle & take_action_ocimem_a;
    assign cmd_b      = idle & ~take_action_ocimem_a & take_action_ocimem_b;
    assign cmd_n      = idle & ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
    assign cmd_drop   = ~idle & any_strobe;
    assign clr_err    = take_action_ocimem_a & jdo[33];

    assign rd_accept  = (state == RD_REQ) & ~mem_waitrequest;
    assign wr_accept  = (state == WR_REQ) & ~mem_waitrequest;
    assign rd_done    = (state == RD_WAIT) & (lat_cnt == 2'd1);

`ifdef OCIMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_req;

    assign in_req  = (state == RD_REQ) | (state == WR_REQ);
    assign timeout = in_req & mem_waitrequest & (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (in_req & mem_waitrequest & ~timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign unused_ok = ^{jdo[37:35], jdo[1:0]};
`else
    // Requests wait forever; TIMEOUT is folded into the unused sink so the parameter stays declared.
    assign timeout   = 1'b0;
    assign unused_ok = ^{jdo[37:35], jdo[1:0], TIMEOUT[0]};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_a) begin
                    state_nxt = jdo[34] ? RD_REQ : IDLE;
                end else if (cmd_b) begin
                    state_nxt = WR_REQ;
                end else if (cmd_n) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (!mem_waitrequest) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 2'd1) begin
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                if (timeout || !mem_waitrequest) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request strobes decode straight from state so reset drops them asynchronously.
    always_comb begin
        busy   = (state != IDLE);
        mem_rd = (state == RD_REQ);
        mem_wr = (state == WR_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (rd_accept) begin
            lat_cnt <= 2'(RD_LATENCY);
        end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            MonDReg   <= '0;
        end else begin
            if (cmd_a) begin
                mem_addr <= jdo[ADDR_W+1:2];
            end else if (rd_done || wr_accept) begin
                mem_addr <= mem_addr + 1'b1;
            end
            if (cmd_b) begin
                mem_wdata <= jdo[34:3];
            end
            if (rd_done) begin
                MonDReg <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            monitor_ready <= 1'b0;
        end else if (cmd_a) begin
            monitor_ready <= ~jdo[34];
        end else if (cmd_b || cmd_n) begin
            monitor_ready <= 1'b0;
        end else if (rd_done || wr_accept || timeout) begin
            monitor_ready <= 1'b1;
        end
    end

    // Error is sticky; an explicit clear beats a set landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            monitor_error <= 1'b0;
        end else if (clr_err) begin
            monitor_error <= 1'b0;
        end else if (cmd_drop || timeout) begin
            monitor_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_system_nios2_ocimem_sequencer.sv
// Self-checking bench for system_nios2_ocimem_sequencer: directed scenarios plus random
// command traffic against a transaction-level model of the debug RAM and monitor registers.
module tb_system_nios2_ocimem_sequencer;

    localparam int TB_TIMEOUT = 8;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_waitrequest;

    system_nios2_ocimem_sequencer #(
        .ADDR_W    (8),
        .RD_LATENCY(1),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .busy                   (busy),
        .mem_addr               (mem_addr),
        .mem_rd                 (mem_rd),
        .mem_wr                 (mem_wr),
        .mem_wdata              (mem_wdata),
        .mem_rdata              (mem_rdata),
        .mem_waitrequest        (mem_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] model_mem [256];
    logic [7:0]  model_addr;
    logic [31:0] model_mondreg;
    logic        model_err;
    logic [31:0] model_wdata;

    // Environment controls.
    logic [31:0] ram [256];
    logic        load_ram = 1'b0;
    logic        stuck = 1'b0;
    logic        rand_wait = 1'b0;
    int          hold_n = 0;
    int          held_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Debug RAM: 1-cycle read latency, garbage on rdata whenever no read was accepted.
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= model_mem[i];
        end else if (mem_wr && !mem_waitrequest) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_rd && !mem_waitrequest) mem_rdata <= ram[mem_addr];
        else mem_rdata <= $urandom;
    end

    always @(negedge clk) begin
        if (!(mem_rd || mem_wr)) held_cnt = 0;
        if (stuck) begin
            mem_waitrequest = 1'b1;
        end else if ((mem_rd || mem_wr) && held_cnt < hold_n) begin
            mem_waitrequest = 1'b1;
            held_cnt++;
        end else if (rand_wait) begin
            mem_waitrequest = ($urandom_range(0, 2) == 0);
        end else begin
            mem_waitrequest = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] make_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[9:2] = addr;
        j[34]  = rd;
        j[33]  = clr;
        return j;
    endfunction

    function automatic logic [37:0] make_b(input logic [31:0] wd);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[34:3] = wd;
        return j;
    endfunction

    // Holds the strobes for exactly one rising edge; returns 1 time unit after that edge.
    task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = n;
        @(posedge clk);
        #1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic saw_wr);
        int n;
        n = 0;
        saw_wr = 1'b0;
        while (!(monitor_ready && !busy) && n < 200) begin
            saw_wr |= mem_wr;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, {31'b0, monitor_ready & ~busy}, 32'd1);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_mondreg"}, MonDReg, model_mondreg);
        check({tag, "_addr"}, {24'b0, mem_addr}, {24'b0, model_addr});
        check({tag, "_err"}, {31'b0, monitor_error}, {31'b0, model_err});
    endtask

    initial begin
        logic        saw;
        logic [7:0]  a8;
        logic [31:0] wd;
        int          cnt;
        int          kind;
        int          dk;
        logic        clr;
        logic        drop;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = $urandom;
        model_mem[8'h10] = 32'hCAFEF00D;
        model_addr = '0;
        model_mondreg = '0;
        model_err = 1'b0;
        model_wdata = '0;
        load_ram = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_ram = 1'b0;

        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", {31'b0, monitor_ready}, 32'd0);
        check("rst_busy_rd_wr", {29'b0, busy, mem_rd, mem_wr}, 32'd0);
        check_model("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait read at 0x10: ready exactly three cycles after the strobe cycle.
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h10, 1'b1, 1'b0));
        check("rd_t1_mem_rd", {30'b0, mem_rd, monitor_ready}, 32'd2);
        @(posedge clk);
        #1;
        check("rd_t2_ready", {30'b0, mem_rd, monitor_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rd_t3_ready", {31'b0, monitor_ready}, 32'd1);
        model_mondreg = 32'hCAFEF00D;
        model_addr = 8'h11;
        check_model("rd_10");

        // Write 0x12345678 at 0x20 with three stall cycles.
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h20, 1'b0, 1'b0));
        check("addr_load_ready", {31'b0, monitor_ready & ~busy}, 32'd1);
        hold_n = 3;
        strobe(1'b0, 1'b1, 1'b0, make_b(32'h12345678));
        cnt = 0;
        for (int i = 0; i < 20 && !monitor_ready; i++) begin
            if (mem_wr) cnt++;
            @(posedge clk);
            #1;
        end
        hold_n = 0;
        check("wr_hold_cycles", cnt, 32'd4);
        check("wr_ready", {31'b0, monitor_ready & ~busy}, 32'd1);
        check("wr_ram", ram[8'h20], 32'h12345678);
        model_mem[8'h20] = 32'h12345678;
        model_wdata = 32'h12345678;
        model_addr = 8'h21;
        check_model("wr_20");

        // Streaming reads wrapping through 0xFF -> 0x00 -> 0x01.
        strobe(1'b1, 1'b0, 1'b0, make_a(8'hFF, 1'b0, 1'b0));
        model_addr = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            strobe(1'b0, 1'b0, 1'b1, make_a(8'h00, 1'b0, 1'b0));
            wait_done("wrap", saw);
            model_mondreg = model_mem[model_addr];
            model_addr = model_addr + 8'd1;
            check_model("wrap");
        end

        // Write strobe while a read is in flight: dropped, error set, read unaffected.
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h30, 1'b1, 1'b0));
        strobe(1'b0, 1'b1, 1'b0, make_b(32'hDEADBEEF));
        check("drop_err_now", {31'b0, monitor_error}, 32'd1);
        wait_done("drop", saw);
        check("drop_no_wr", {31'b0, saw}, 32'd0);
        model_mondreg = model_mem[8'h30];
        model_addr = 8'h31;
        model_err = 1'b1;
        check_model("drop");
        check("drop_wdata_kept", mem_wdata, model_wdata);
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h31, 1'b0, 1'b1));
        model_err = 1'b0;
        check_model("clr_err");

        // ocimem_a and ocimem_b together: only the address load/read happens.
        strobe(1'b1, 1'b1, 1'b0, make_a(8'h40, 1'b1, 1'b0));
        wait_done("prio", saw);
        check("prio_no_wr", {31'b0, saw}, 32'd0);
        model_mondreg = model_mem[8'h40];
        model_addr = 8'h41;
        check_model("prio");
        check("prio_wdata_kept", mem_wdata, model_wdata);

        // Random command traffic with random waitrequest and occasional dropped strobes.
        rand_wait = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            a8 = 8'($urandom);
            clr = ($urandom_range(0, 3) == 0);
            drop = (kind != 0) && ($urandom_range(0, 2) == 0);
            case (kind)
                0, 1: begin
                    strobe(1'b1, 1'($urandom), 1'($urandom), make_a(a8, kind == 1, clr));
                    model_addr = a8;
                    if (clr) model_err = 1'b0;
                    if (kind == 1) begin
                        model_mondreg = model_mem[a8];
                        model_addr = a8 + 8'd1;
                    end
                end
                2: begin
                    wd = $urandom;
                    strobe(1'b0, 1'b1, 1'($urandom), make_b(wd));
                    model_mem[model_addr] = wd;
                    model_wdata = wd;
                    model_addr = model_addr + 8'd1;
                end
                default: begin
                    strobe(1'b0, 1'b0, 1'b1, make_a(a8, 1'b1, 1'b0));
                    model_mondreg = model_mem[model_addr];
                    model_addr = model_addr + 8'd1;
                end
            endcase
            if (drop) begin
                dk = $urandom_range(0, 2);
                strobe(dk == 0, dk == 1, dk == 2, make_a(8'($urandom), 1'($urandom), 1'b0));
                model_err = 1'b1;
            end
            wait_done("rand", saw);
            check_model("rand");
            check("rand_wdata", mem_wdata, model_wdata);
        end
        rand_wait = 1'b0;
        @(posedge clk);
        #1;

`ifdef OCIMEM_TIMEOUT_EN
        // Waitrequest stuck high: the watchdog abandons the read after TIMEOUT cycles.
        stuck = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h50, 1'b1, 1'b0));
        cnt = 0;
        for (int i = 0; i < 40 && mem_rd; i++) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        stuck = 1'b0;
        check("to_rd_cycles", cnt, TB_TIMEOUT);
        check("to_ready", {31'b0, monitor_ready & ~busy}, 32'd1);
        model_addr = 8'h50;
        model_err = 1'b1;
        check_model("timeout");
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h50, 1'b0, 1'b1));
        model_err = 1'b0;
        check_model("to_clr");
`endif

        // Asynchronous reset while the read sits in RD_WAIT.
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h60, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        check("rdwait_busy_rd", {30'b0, busy, mem_rd}, 32'd2);
        reset = 1'b1;
        #1;
        model_addr = '0;
        model_mondreg = '0;
        model_err = 1'b0;
        check("arst_ready_busy", {28'b0, monitor_ready, busy, mem_rd, mem_wr}, 32'd0);
        check("arst_wdata", mem_wdata, 32'h0);
        check_model("arst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", {31'b0, busy}, 32'd0);
        strobe(1'b1, 1'b0, 1'b0, make_a(8'h61, 1'b1, 1'b0));
        wait_done("post_rst", saw);
        model_mondreg = model_mem[8'h61];
        model_addr = 8'h62;
        check_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
